// File: rtl/tz_count_arbiter.sv
// Round-robin arbiter sharing one trailing-zero counter between two FPU requesters.
// A single registered result stage with backpressure returns the count tagged with the owner id.
module tz_count_arbiter #(
  parameter int unsigned SizeMantissa = 23,
  parameter int unsigned TagWidth     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req0_valid,
  output logic                                  req0_ready,
  input  logic [SizeMantissa+1:0]               req0_mantissa,
  input  logic [TagWidth-1:0]                   req0_tag,
  input  logic                                  req1_valid,
  output logic                                  req1_ready,
  input  logic [SizeMantissa+1:0]               req1_mantissa,
  input  logic [TagWidth-1:0]                   req1_tag,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic                                  rsp_id,
  output logic [TagWidth-1:0]                   rsp_tag,
  output logic [$clog2(SizeMantissa+1)-1:0]     rsp_trailing_zeros
);

  localparam int unsigned MantW  = SizeMantissa + 2;
  localparam int unsigned CountW = $clog2(SizeMantissa + 1);
  localparam int unsigned ScanW  = SizeMantissa + 1;

  // Lowest set bit wins; an all-zero scan window yields ScanW.
  function automatic logic [CountW-1:0] count_tz(input logic [ScanW-1:0] m);
    logic [CountW-1:0] tz;
    tz = CountW'(ScanW);
    for (int i = int'(ScanW) - 1; i >= 0; i--) begin
      if (m[i]) tz = CountW'(i);
    end
    return tz;
  endfunction

  logic              last_grant;
  logic              free;
  logic              any_valid;
  logic              grant;
  logic              accept;
  logic [MantW-1:0]  sel_mantissa;
  logic [TagWidth-1:0] sel_tag;
  logic              unused_msb;

  assign free      = !rsp_valid || rsp_ready;
  assign any_valid = req0_valid || req1_valid;

  // On contention favour the requester that did not win last time.
  assign grant  = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign accept = free && any_valid && !reset;

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign sel_mantissa = grant ? req1_mantissa : req0_mantissa;
  assign sel_tag      = grant ? req1_tag : req0_tag;
  assign unused_msb   = sel_mantissa[MantW-1];

  // Result stage: load on accept, drain when consumed with nothing new, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid          <= 1'b0;
      rsp_id             <= 1'b0;
      rsp_tag            <= '0;
      rsp_trailing_zeros <= '0;
      last_grant         <= 1'b1;
    end else if (accept) begin
      rsp_valid          <= 1'b1;
      rsp_id             <= grant;
      rsp_tag            <= sel_tag;
      rsp_trailing_zeros <= count_tz(sel_mantissa[ScanW-1:0]);
      last_grant         <= grant;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tz_count_arbiter.sv
// Directed and randomized checks of tz_count_arbiter against hand-computed values
// and a small arbitration/bit-scan model with an in-order scoreboard.
`timescale 1ns/1ps
module tb_tz_count_arbiter;

  localparam int unsigned SizeMantissa = 23;
  localparam int unsigned TagWidth     = 4;
  localparam int unsigned MantW        = SizeMantissa + 2;
  localparam int unsigned CountW       = $clog2(SizeMantissa + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MantW-1:0]    req0_mantissa, req1_mantissa;
  logic [TagWidth-1:0] req0_tag, req1_tag;
  logic                rsp_valid, rsp_ready, rsp_id;
  logic [TagWidth-1:0] rsp_tag;
  logic [CountW-1:0]   rsp_trailing_zeros;

  int n_tests = 0;
  int n_fail  = 0;

  tz_count_arbiter #(.SizeMantissa(SizeMantissa), .TagWidth(TagWidth)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mantissa(req0_mantissa), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mantissa(req1_mantissa), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_trailing_zeros(rsp_trailing_zeros)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference bit-scan counting upward from bit 0 over the 24-bit window.
  function automatic int model_tz(input logic [MantW-1:0] m);
    int n;
    n = 0;
    while (n < int'(SizeMantissa + 1) && m[n] == 1'b0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic                id;
    logic [TagWidth-1:0] tag;
    logic [7:0]          tz;
  } exp_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [MantW-1:0] bnd_m [4];
    int               bnd_e [4];
    exp_t             q[$];
    exp_t             e;
    logic             m_last, m_free, m_grant, er0, er1, f0, f1;
    int               accepted, cyc;

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_mantissa = '0; req1_mantissa = '0;
    req0_tag = '0; req1_tag = '0;
    rsp_ready = 1'b1;
    #12;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_tag", 32'(rsp_tag), 0);
    check("reset_tz", 32'(rsp_trailing_zeros), 0);
    check("reset_ready0", 32'(req0_ready), 0);
    check("reset_ready1", 32'(req1_ready), 0);

    // Single request on requester 0
    req1_valid = 1'b0;
    req0_mantissa = MantW'(25'h0000008); req0_tag = 4'd3;
    @(negedge clk); reset = 1'b0; #1;
    check("single_ready0", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    check("single_valid", 32'(rsp_valid), 1);
    check("single_id", 32'(rsp_id), 0);
    check("single_tag", 32'(rsp_tag), 3);
    check("single_tz", 32'(rsp_trailing_zeros), 3);
    step();
    check("single_drain", 32'(rsp_valid), 0);

    // Count boundaries on requester 1
    bnd_m[0] = MantW'(25'h0000001); bnd_e[0] = 0;
    bnd_m[1] = MantW'(25'h0800000); bnd_e[1] = 23;
    bnd_m[2] = MantW'(25'h0000000); bnd_e[2] = 24;
    bnd_m[3] = MantW'(25'h1000000); bnd_e[3] = 24;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_mantissa = bnd_m[i]; req1_tag = 4'(i + 8);
      step();
      req1_valid = 1'b0;
      check("bnd_valid", 32'(rsp_valid), 1);
      check("bnd_id", 32'(rsp_id), 1);
      check("bnd_tag", 32'(rsp_tag), 32'(i + 8));
      check("bnd_tz", 32'(rsp_trailing_zeros), 32'(bnd_e[i]));
    end
    step();

    // Contention: requester 1 won last, so order is 0,1,0,1
    req0_valid = 1'b1; req0_mantissa = MantW'(25'h0000020); req0_tag = 4'd5;
    req1_valid = 1'b1; req1_mantissa = MantW'(25'h0000100); req1_tag = 4'd6;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      check("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      step();
      check("cont_valid", 32'(rsp_valid), 1);
      check("cont_id", 32'(rsp_id), 32'(i % 2));
      check("cont_tz", 32'(rsp_trailing_zeros), (i % 2 == 0) ? 5 : 8);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Backpressure then same-cycle drain and accept
    req0_valid = 1'b1; req0_mantissa = MantW'(25'h0000010); req0_tag = 4'd7;
    step();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_mantissa = MantW'(25'h0000004); req1_tag = 4'd9;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready0", 32'(req0_ready), 0);
      check("bp_ready1", 32'(req1_ready), 0);
      step();
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_tag", 32'(rsp_tag), 7);
      check("bp_tz", 32'(rsp_trailing_zeros), 4);
    end
    rsp_ready = 1'b1; #1;
    check("bp_release_ready1", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    check("bp_swap_valid", 32'(rsp_valid), 1);
    check("bp_swap_id", 32'(rsp_id), 1);
    check("bp_swap_tag", 32'(rsp_tag), 9);
    check("bp_swap_tz", 32'(rsp_trailing_zeros), 2);

    // Reset mid-operation while a result is held and both requesters wait
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_mantissa = MantW'(25'h0000002); req0_tag = 4'd1;
    req1_valid = 1'b1; req1_mantissa = MantW'(25'h0000040); req1_tag = 4'd2;
    #2;
    check("mid_pre_valid", 32'(rsp_valid), 1);
    reset = 1'b1; #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ready0", 32'(req0_ready), 0);
    check("mid_rst_ready1", 32'(req1_ready), 0);
    @(negedge clk); reset = 1'b0; rsp_ready = 1'b1; #1;
    check("mid_first_ready0", 32'(req0_ready), 1);
    check("mid_first_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("mid_first_id", 32'(rsp_id), 0);
    check("mid_first_tz", 32'(rsp_trailing_zeros), 1);
    step();
    check("mid_drain", 32'(rsp_valid), 0);

    // Random traffic against arbitration model and in-order scoreboard
    m_last = 1'b0; f0 = 1'b0; f1 = 1'b0; accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      if (f0) req0_valid = 1'b0;
      if (f1) req1_valid = 1'b0;
      if (!req0_valid && accepted < 10000 && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1;
        req0_mantissa = ($urandom_range(0, 15) == 0) ? '0 : MantW'($urandom << $urandom_range(0, 26));
        req0_tag = TagWidth'($urandom);
      end
      if (!req1_valid && accepted < 10000 && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1;
        req1_mantissa = ($urandom_range(0, 15) == 0) ? '0 : MantW'($urandom << $urandom_range(0, 26));
        req1_tag = TagWidth'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      m_free = (q.size() == 0) || rsp_ready;
      if (q.size() != 0 && rsp_ready) begin
        e = q.pop_front();
        check("rnd_id", 32'(rsp_id), 32'(e.id));
        check("rnd_tag", 32'(rsp_tag), 32'(e.tag));
        check("rnd_tz", 32'(rsp_trailing_zeros), 32'(e.tz));
      end
      m_grant = (req0_valid && req1_valid) ? !m_last : req1_valid;
      er0 = m_free && req0_valid && !m_grant;
      er1 = m_free && req1_valid && m_grant;
      check("rnd_ready0", 32'(req0_ready), 32'(er0));
      check("rnd_ready1", 32'(req1_ready), 32'(er1));
      f0 = er0; f1 = er1;
      if (er0 || er1) begin
        e.id  = m_grant;
        e.tag = m_grant ? req1_tag : req0_tag;
        e.tz  = 8'(model_tz(m_grant ? req1_mantissa : req0_mantissa));
        q.push_back(e);
        m_last = m_grant;
        accepted++;
      end
      step();
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    check("rnd_accept_count", 32'(accepted), 10000);
    if (q.size() == 1) begin
      e = q.pop_front();
      check("rnd_last_id", 32'(rsp_id), 32'(e.id));
      check("rnd_last_tag", 32'(rsp_tag), 32'(e.tag));
      check("rnd_last_tz", 32'(rsp_trailing_zeros), 32'(e.tz));
    end
    check("rnd_queue_empty", 32'(q.size()), 0);
    step();
    check("rnd_final_valid", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tz_count_arbiter.md
Name: tz_count_arbiter

Overview:
- Shares one trailing-zero counter datapath between two FPU requesters: requester 0 is the rounding/sticky unit, requester 1 is the fcvt conversion unit.
- Round-robin arbitration on valid/ready request channels.
- One registered result stage drives a single response channel tagged with the requester id, with backpressure.
- Sits between the FP execute sub-units and the shared trailing-zero count logic.

Parameters:
- SizeMantissa, 23, mantissa fraction width (23 single, 52 double).
- TagWidth, 4, width of the opaque tag carried with each request.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand.
- req0_ready  output  1  requester 0 operand accepted this cycle.
- req0_mantissa  input  SizeMantissa+2  requester 0 operand.
- req0_tag  input  TagWidth  requester 0 tag.
- req1_valid  input  1  requester 1 has an operand.
- req1_ready  output  1  requester 1 operand accepted this cycle.
- req1_mantissa  input  SizeMantissa+2  requester 1 operand.
- req1_tag  input  TagWidth  requester 1 tag.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_id  output  1  requester that owns the result (0/1).
- rsp_tag  output  TagWidth  tag of the request.
- rsp_trailing_zeros  output  $clog2(SizeMantissa+1)  count result.

Behaviour:
- Count function:
  - Number of consecutive zero bits starting at bit 0, scanning bits [SizeMantissa:0] only.
  - Bit SizeMantissa+1 is ignored.
  - If bits [SizeMantissa:0] are all zero, result is SizeMantissa+1 (24 for default). The output width holds this value.
- Stage free condition: free = !rsp_valid || rsp_ready.
- Arbitration, evaluated combinationally each cycle:
  - Only one of req0_ready/req1_ready may be high in a cycle; both low when !free.
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant the requester not granted most recently (last_grant register).
  - readyN = free && grantN. readyN never depends on readyN of the same port; it may depend on validN.
- Handshake:
  - Transfer on validN && readyN.
  - Requesters hold valid, mantissa and tag stable until accepted; the arbiter does not check this.
- Accept cycle, at the clock edge:
  - rsp_valid <= 1.
  - rsp_id <= granted index.
  - rsp_tag <= granted tag.
  - rsp_trailing_zeros <= count of granted mantissa.
  - last_grant <= granted index.
- Latency and throughput:
  - Result is visible the cycle after acceptance (latency 1).
  - Full throughput: 1 result per cycle while rsp_ready stays high.
- Drain with no new accept: rsp_valid && rsp_ready && no grant -> rsp_valid <= 0. rsp_id, rsp_tag and rsp_trailing_zeros hold their last values.
- Backpressure:
  - rsp_valid && !rsp_ready -> all rsp_* outputs hold.
  - Both ready outputs are low, so no new accept occurs.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1. Neither requester waits more than one grant.
- Reset values (asynchronous, takes effect immediately, any state):
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_trailing_zeros=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready=0 and req1_ready=0 while reset is high.
  - A result held in the stage at reset is discarded; no response is produced for it.
- After reset deasserts, the arbiter accepts on the first rising edge.

Test Plan:
- Reset then single request: req0 mantissa=0x000_0008, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, id=0, tag=3, trailing_zeros=3; the following cycle rsp_valid=0.
- Boundaries on requester 1, one request each:
  - 0x0000001 -> 0.
  - 0x0800000 (bit 23) -> 23.
  - 0x0000000 -> 24.
  - 0x1000000 (bit 24 only) -> 24 (bit ignored).
- Contention with both valid for 4 cycles, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence matches; results back-to-back with rsp_valid never dropping.
- Backpressure:
  - req0 accepted, then rsp_ready=0 for 3 cycles -> rsp_* stable, req0_ready=0 and req1_ready=0.
  - Raise rsp_ready with req1 valid -> same-cycle drain and accept; rsp_valid stays 1; req1 result appears next cycle.
- Reset mid-operation: assert reset while rsp_valid=1 and both requesters valid -> rsp_valid=0 immediately without a clock edge; after release, first contention grants requester 0.
- Random: 10000 random mantissas on both ports with random valid and rsp_ready -> every accepted request produces exactly one response, in order, with the correct id/tag and the count from the bit-scan model; error count 0.
